// File: rtl/dram2gb_loader.sv
// dram2gb_loader: streams batches from a memory read port into a ping-pong global buffer
module dram2gb_loader #(
  parameter int BATCH_SIZE      = 128,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic [ADDR_WIDTH-1:0]         base_addr,
  input  logic [15:0]                   num_batches,
  output logic                          mem_req_valid,
  input  logic                          mem_req_ready,
  output logic [ADDR_WIDTH-1:0]         mem_req_addr,
  input  logic                          mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]         mem_rsp_data,
  output logic                          gb_wr_en,
  output logic                          gb_wr_bank,
  output logic [$clog2(BATCH_SIZE)-1:0] gb_wr_addr,
  output logic [DATA_WIDTH-1:0]         gb_wr_data,
  output logic [1:0]                    batch_valid,
  input  logic [1:0]                    batch_release,
  output logic                          busy,
  output logic                          done
);
  localparam int IW = $clog2(BATCH_SIZE);
  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [IW:0]           BS_C  = (IW+1)'(BATCH_SIZE);
  localparam logic [IW-1:0]         LAST  = IW'(BATCH_SIZE - 1);
  localparam logic [OW-1:0]         MAX_O = OW'(MAX_OUTSTANDING);
  localparam logic [ADDR_WIDTH-1:0] STEP  = ADDR_WIDTH'(DATA_WIDTH / 8);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT_BANK, FINISH} state_t;

  state_t                state, state_nx;
  logic                  bank;
  logic [IW:0]           req_cnt;
  logic [IW-1:0]         rsp_idx;
  logic [OW-1:0]         outstanding;
  logic [15:0]           batch_cnt, num_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic                  accept, fire, batch_done, last_batch, next_taken;

  assign accept        = start && state == IDLE;
  assign fire          = mem_req_valid && mem_req_ready;
  assign batch_done    = state == FETCH && gb_wr_en && gb_wr_addr == LAST;
  assign last_batch    = batch_cnt + 16'd1 == num_r;
  assign next_taken    = batch_valid[~bank] && !batch_release[~bank];
  assign mem_req_valid = state == FETCH && outstanding < MAX_O && req_cnt < BS_C;
  assign mem_req_addr  = addr_r;
  assign busy          = state != IDLE;
  assign done          = state == FINISH;

  // next-state selection; a bank released in the deciding cycle counts as free
  always_comb begin
    state_nx = state;
    if (state == IDLE && start)
      state_nx = num_batches == 16'd0 ? FINISH : (batch_valid[0] && !batch_release[0]) ? WAIT_BANK : FETCH;
    if (batch_done)
      state_nx = last_batch ? FINISH : next_taken ? WAIT_BANK : FETCH;
    if (state == WAIT_BANK && batch_valid[bank] && batch_release[bank])
      state_nx = FETCH;
    if (state == FINISH)
      state_nx = IDLE;
  end

  // state register
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;

  // job bookkeeping: addresses, per-batch counters, in-flight count, bank pointer
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      addr_r      <= '0;
      num_r       <= '0;
      bank        <= 1'b0;
      req_cnt     <= '0;
      rsp_idx     <= '0;
      batch_cnt   <= '0;
      outstanding <= '0;
    end else if (accept) begin
      addr_r      <= base_addr;
      num_r       <= num_batches;
      bank        <= 1'b0;
      req_cnt     <= '0;
      rsp_idx     <= '0;
      batch_cnt   <= '0;
      outstanding <= '0;
    end else begin
      if (fire) addr_r <= addr_r + STEP;
      outstanding <= outstanding + OW'(fire) - OW'(mem_rsp_valid);
      if (mem_rsp_valid) rsp_idx <= rsp_idx + IW'(1);
      if (batch_done) begin
        bank      <= ~bank;
        req_cnt   <= '0;
        batch_cnt <= batch_cnt + 16'd1;
      end else if (fire) req_cnt <= req_cnt + (IW+1)'(1);
    end

  // registered global-buffer write of each response
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      gb_wr_en   <= 1'b0;
      gb_wr_bank <= 1'b0;
      gb_wr_addr <= '0;
      gb_wr_data <= '0;
    end else begin
      gb_wr_en <= mem_rsp_valid;
      if (mem_rsp_valid) begin
        gb_wr_bank <= bank;
        gb_wr_addr <= rsp_idx;
        gb_wr_data <= mem_rsp_data;
      end
    end

  // bank-full flags: set on batch completion, cleared by consumer release
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) batch_valid <= 2'b00;
    else batch_valid <= (batch_valid & ~batch_release) | (batch_done ? {bank, ~bank} : 2'b00);
endmodule
